uart_rx_packetizer: RTL

//  Sequences the 8N1 byte receiver into framed command packets for the core.

---
 rtl/uart_pkt_pkg.sv | 18 +
 rtl/uart_pkt_buf.sv | 28 ++
 rtl/uart_rx_packetizer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared constants for the UART command packetizer: FSM state encodings,
// the default frame start marker and the length/index width helper.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    // Bits needed to hold a length value in 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x WIDTH register file with one synchronous write
// port and one asynchronous read port.
module uart_pkt_buf #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; every entry is written before
    // it is read, and a reset would turn the array into plain flops.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_packetizer.sv
// Frames the UART receiver byte stream into SYNC/LEN/payload/CHK packets,
// validates them and drains the payload on a valid/ready stream.
module uart_rx_packetizer
    import uart_pkt_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               MAX_LEN      = 16,
    parameter int               CLK_FREQ     = 50_000_000,
    parameter int               BAUD_RATE    = 115_200,
    parameter int               TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * 20,
    parameter logic [WIDTH-1:0] SYNC         = WIDTH'(SYNC_BYTE)
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic [WIDTH-1:0]                rx_data_i,
    input  logic                            rx_valid_i,
    output logic [WIDTH-1:0]                pkt_data_o,
    output logic                            pkt_valid_o,
    output logic                            pkt_last_o,
    input  logic                            pkt_ready_i,
    output logic [len_width(MAX_LEN)-1:0]   pkt_len_o,
    output logic                            busy_o,
    output logic                            err_chk_o,
    output logic                            err_len_o,
    output logic                            err_timeout_o,
    output logic                            err_overrun_o
);

    localparam int LEN_W  = len_width(MAX_LEN);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] chk_q, chk_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_chk_q, err_chk_d;
    logic             err_len_q, err_len_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_overrun_q, err_overrun_d;

    logic             buf_we;
    logic [WIDTH-1:0] buf_rdata;
    logic             timed;
    logic             expired;
    logic             at_last;
    logic             len_ok;

    uart_pkt_buf #(
        .DEPTH  (MAX_LEN),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clock_i (clock_i),
        .we_i    (buf_we),
        .waddr_i (idx_q[ADDR_W-1:0]),
        .wdata_i (rx_data_i),
        .raddr_i (idx_q[ADDR_W-1:0]),
        .rdata_o (buf_rdata)
    );

    assign timed   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign expired = !rx_valid_i && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
    assign at_last = (idx_q == len_q - LEN_W'(1));
    assign len_ok  = (rx_data_i != '0) && (int'(rx_data_i) <= MAX_LEN);

    // NOTE: every variable gets a default at the top of the block so that no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        to_cnt_d      = '0;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        buf_we        = 1'b0;

        if (timed && !rx_valid_i) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            ST_HUNT: begin
                if (rx_valid_i && rx_data_i == SYNC) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid_i) begin
                    if (len_ok) begin
                        len_d   = LEN_W'(rx_data_i);
                        chk_d   = rx_data_i;
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else if (expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid_i) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ rx_data_i;
                    if (at_last) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end else if (expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end
            end
            ST_CHECK: begin
                if (rx_valid_i) begin
                    if (rx_data_i == chk_q) begin
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else if (expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end
            end
            ST_DRAIN: begin
                // No backpressure upstream: bytes arriving now are lost.
                if (rx_valid_i) begin
                    err_overrun_d = 1'b1;
                end
                if (pkt_ready_i) begin
                    if (at_last) begin
                        state_d = ST_HUNT;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_HUNT;
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            to_cnt_q      <= '0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            to_cnt_q      <= to_cnt_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign pkt_valid_o   = (state_q == ST_DRAIN);
    assign pkt_data_o    = pkt_valid_o ? buf_rdata : '0;
    assign pkt_last_o    = pkt_valid_o && at_last;
    assign pkt_len_o     = pkt_valid_o ? len_q : '0;
    assign busy_o        = (state_q != ST_HUNT);
    assign err_chk_o     = err_chk_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_timeout_q;
    assign err_overrun_o = err_overrun_q;

endmodule
